ps2_keystroke_filter: RTL
=========================

Name: ps2_keystroke_filter

Overview:
- Sits between the PS/2 receiver (byte stream `received_data` / `received_data_en`) and the game-control FSM.
- Decodes PS/2 set-2 framing:
  - strips break (F0) sequences and extended (E0) prefixes;
  - discards the Pause (E1) sequence and device status bytes;
  - suppresses typematic auto-repeat.
- Queues one entry per genuine keypress in a small FIFO with a valid/ack handshake, so that keystrokes arriving while the game FSM is busy are not lost.

Parameters:
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries (default 4).

Ports:
- clk  input  1  system clock (CLOCK_50 domain)
- resetn  input  1  asynchronous active-low reset
- received_data  input  8  byte from PS/2 receiver
- received_data_en  input  1  one-cycle strobe, received_data valid
- flush  input  1  synchronous FIFO clear (e.g. new level)
- key_ack  input  1  consumer pops head entry; ignored when key_valid=0
- key_valid  output  1  FIFO non-empty
- key_data  output  8  make code at FIFO head
- key_ext  output  1  head entry was E0-prefixed
- fifo_count  output  FIFO_AW+1  occupancy 0..2**FIFO_AW
- overflow  output  1  sticky: a keypress was dropped because the FIFO was full

Behaviour:
- Reset (resetn=0, asynchronous):
  - FIFO empty; key_valid=0, key_data=8'h00, key_ext=0, fifo_count=0, overflow=0.
  - Decoder state = S_IDLE; held_valid=0.
- Decoder FSM advances only on cycles where received_data_en=1.
- S_IDLE:
  - E0 -> S_EXT.
  - F0 -> S_BRK.
  - E1 -> S_SKIP with skip_cnt=7.
  - AA, FA, FE, EE, 00, FF -> discarded, stay S_IDLE.
  - Any other byte -> make(code, ext=0).
- S_EXT:
  - F0 -> S_EXT_BRK.
  - E0 -> stay S_EXT.
  - 12 or 59 (fake shifts) -> discarded, S_IDLE.
  - Other -> make(code, ext=1), S_IDLE.
- S_BRK: any byte -> break(code, ext=0), S_IDLE.
- S_EXT_BRK: any byte -> break(code, ext=1), S_IDLE.
- S_SKIP: decrement skip_cnt on each byte; return to S_IDLE on the byte that takes skip_cnt to 0. Nothing is queued.
- make(c,e):
  - If held_valid and {held_ext,held_code}=={e,c}: repeat -> not queued.
  - Otherwise push {e,c}; set held_code=c, held_ext=e, held_valid=1.
- break(c,e): if it matches the held key, held_valid=0; otherwise no change. Never queued.
- Push timing: the entry is written on the same edge that samples the final byte. key_valid, key_data and key_ext reflect it from the next cycle (1-cycle latency).
- FIFO:
  - key_data/key_ext are driven combinationally from the head entry.
  - Pop on key_ack & key_valid; the next entry appears the following cycle.
  - Pointers wrap modulo 2**FIFO_AW.
  - fifo_count is a registered count.
- Push and pop in the same cycle: both take effect, count unchanged. This applies even when full, so the push succeeds.
- Push when full without pop: entry dropped, overflow<=1. overflow clears only on reset.
- flush:
  - Empties the FIFO next cycle: pointers and count go to 0; key_valid=0 the following cycle.
  - Flush wins over push and pop in the same cycle.
  - The decoder FSM and held-key tracking still process any byte that cycle, so a make on a flush cycle is lost but sets held.
- Pulses are all single-cycle; received_data_en held high for N cycles is treated as N bytes.
- Reset mid-sequence (e.g. after E0 or F0) returns to S_IDLE. The first byte after reset is decoded from S_IDLE.

Optional Feature:
- Macro: PS2_KEYSTROKE_REPEAT_EN.
- Defined: typematic repeats are queued. A make matching the held key is pushed like any new make; held tracking is still maintained.
- Undefined (default): repeats are suppressed as specified above.

Test Plan:
- Bytes 1C, F0, 1C -> exactly one entry {ext=0, data=1C}; key_valid rises 1 cycle after the 1C strobe; fifo_count=1.
- Bytes 1C,1C,1C,F0,1C,1C -> two entries of 1C with macro undefined; four entries with PS2_KEYSTROKE_REPEAT_EN defined.
- Bytes E0, 75, E0, F0, 75 -> one entry {ext=1, 75}. Bytes E1,14,77,E1,F0,14,F0,77 -> no entries, FSM back in S_IDLE.
- Five distinct makes 16,1E,26,25,2E with no ack (depth 4) -> fifo_count=4, overflow=1; pops return 16,1E,26,25 in order. A push with simultaneous ack when full -> count stays 4, overflow unchanged.
- 3 entries queued, flush asserted with a make 5A strobe in the same cycle -> fifo_count=0 next cycle. A subsequent 5A make is suppressed as a repeat (macro undefined); F0,5A then 5A -> one entry 5A.
- Assert resetn=0 asynchronously after a lone F0 -> all outputs at reset values immediately. The next byte 29 -> entry 29, not treated as a break.

Source files
------------

// File: rtl/ps2_keystroke_filter.sv
// PS/2 set-2 keystroke filter: strips break/extended framing, Pause and status bytes,
// suppresses typematic repeats and queues genuine makes in a small FIFO.
// Optional macro PS2_KEYSTROKE_REPEAT_EN: queue typematic repeats as well.
module ps2_keystroke_filter #(
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [7:0]         received_data,
  input  logic               received_data_en,
  input  logic               flush,
  input  logic               key_ack,
  output logic               key_valid,
  output logic [7:0]         key_data,
  output logic               key_ext,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_SKIP} state_t;

  state_t               state_q, state_d;
  logic [2:0]           skip_q, skip_d;
  logic [7:0]           held_code_q, held_code_d;
  logic                 held_ext_q, held_ext_d;
  logic                 held_valid_q, held_valid_d;

  logic                 is_make, is_brk, ext, match, push;
  logic [8:0]           push_entry;

  logic [8:0]           mem_q [DEPTH];
  logic [FIFO_AW-1:0]   wr_q, rd_q;
  logic [FIFO_AW:0]     cnt_q;
  logic                 ovf_q;
  logic                 full, pop, wr_en;

  always_comb begin
    state_d      = state_q;
    skip_d       = skip_q;
    held_code_d  = held_code_q;
    held_ext_d   = held_ext_q;
    held_valid_d = held_valid_q;
    is_make      = 1'b0;
    is_brk       = 1'b0;
    ext          = 1'b0;
    push         = 1'b0;
    if (received_data_en) begin
      case (state_q)
        S_IDLE: begin
          case (received_data)
            8'hE0: state_d = S_EXT;
            8'hF0: state_d = S_BRK;
            8'hE1: begin
              state_d = S_SKIP;
              skip_d  = 3'd7;
            end
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: state_d = S_IDLE;
            default: is_make = 1'b1;
          endcase
        end
        S_EXT: begin
          case (received_data)
            8'hF0: state_d = S_EXT_BRK;
            8'hE0: state_d = S_EXT;
            // Fake shifts emitted around extended keys carry no keypress.
            8'h12, 8'h59: state_d = S_IDLE;
            default: begin
              is_make = 1'b1;
              ext     = 1'b1;
              state_d = S_IDLE;
            end
          endcase
        end
        S_BRK: begin
          is_brk  = 1'b1;
          state_d = S_IDLE;
        end
        S_EXT_BRK: begin
          is_brk  = 1'b1;
          ext     = 1'b1;
          state_d = S_IDLE;
        end
        S_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    match = held_valid_q && ({held_ext_q, held_code_q} == {ext, received_data});
    if (is_make) begin
`ifdef PS2_KEYSTROKE_REPEAT_EN
      push = 1'b1;
`else
      push = !match;
`endif
      held_code_d  = received_data;
      held_ext_d   = ext;
      held_valid_d = 1'b1;
    end
    if (is_brk && match) held_valid_d = 1'b0;
    push_entry = {ext, received_data};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      skip_q       <= 3'd0;
      held_code_q  <= 8'h00;
      held_ext_q   <= 1'b0;
      held_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      skip_q       <= skip_d;
      held_code_q  <= held_code_d;
      held_ext_q   <= held_ext_d;
      held_valid_q <= held_valid_d;
    end
  end

  // A push into a full FIFO still succeeds when the head is popped that same cycle.
  assign full  = (cnt_q == (FIFO_AW+1)'(DEPTH));
  assign pop   = key_ack & key_valid;
  assign wr_en = push & ~flush & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= push_entry;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign key_valid  = (cnt_q != '0);
  assign key_data   = key_valid ? mem_q[rd_q][7:0] : 8'h00;
  assign key_ext    = key_valid ? mem_q[rd_q][8] : 1'b0;
  assign fifo_count = cnt_q;
  assign overflow   = ovf_q;

endmodule
